// File: rtl/gpio_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpio_ctrl : two-bank GPIO with rising-edge interrupt status
// Revision  : 1.0
// ----------------------------------------------------------------------------
module gpio_ctrl #(
  parameter int B1_BW = 8,
  parameter int B0_BW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [3:0]       addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o,
  output logic             ack_o,
  output logic [B1_BW-1:0] b1_data_o,
  output logic [B1_BW-1:0] b1_oe_o,
  input  logic [B1_BW-1:0] b1_data_i,
  output logic [B0_BW-1:0] b0_data_o,
  output logic [B0_BW-1:0] b0_oe_o,
  input  logic [B0_BW-1:0] b0_data_i,
  output logic             irq_o
);

  logic [B0_BW-1:0] out0, dir0, ie0, is0, sync_a0, sync_b0, hist0;
  logic [B1_BW-1:0] out1, dir1, ie1, is1, sync_a1, sync_b1, hist1;
  logic [B0_BW-1:0] rise0, clr0;
  logic [B1_BW-1:0] rise1, clr1;
  logic [1:0]       warm;
  logic             edge_en;
  logic             wr;
  logic [7:0]       rd_mux;

  assign b0_data_o = out0;
  assign b0_oe_o   = dir0;
  assign b1_data_o = out1;
  assign b1_oe_o   = dir1;

  // History only holds a genuine post-reset pad sample once warm saturates.
  assign edge_en = (warm == 2'd3);
  assign rise0   = edge_en ? (sync_b0 & ~hist0) : '0;
  assign rise1   = edge_en ? (sync_b1 & ~hist1) : '0;
  assign wr      = req_i & we_i;
  assign clr0    = (wr && addr_i == 4'h8) ? wdata_i[B0_BW-1:0] : '0;
  assign clr1    = (wr && addr_i == 4'h9) ? wdata_i[B1_BW-1:0] : '0;

  always_comb begin
    rd_mux = 8'h00;
    case (addr_i)
      4'h0: rd_mux[B0_BW-1:0] = out0;
      4'h1: rd_mux[B1_BW-1:0] = out1;
      4'h2: rd_mux[B0_BW-1:0] = dir0;
      4'h3: rd_mux[B1_BW-1:0] = dir1;
      4'h4: rd_mux[B0_BW-1:0] = sync_b0;
      4'h5: rd_mux[B1_BW-1:0] = sync_b1;
      4'h6: rd_mux[B0_BW-1:0] = ie0;
      4'h7: rd_mux[B1_BW-1:0] = ie1;
      4'h8: rd_mux[B0_BW-1:0] = is0;
      4'h9: rd_mux[B1_BW-1:0] = is1;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0    <= '0;
      dir0    <= '0;
      ie0     <= '0;
      is0     <= '0;
      sync_a0 <= '0;
      sync_b0 <= '0;
      hist0   <= '0;
      out1    <= '0;
      dir1    <= '0;
      ie1     <= '0;
      is1     <= '0;
      sync_a1 <= '0;
      sync_b1 <= '0;
      hist1   <= '0;
      warm    <= 2'd0;
      ack_o   <= 1'b0;
      rdata_o <= 8'h00;
      irq_o   <= 1'b0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= (req_i && !we_i) ? rd_mux : 8'h00;
      sync_a0 <= b0_data_i;
      sync_b0 <= sync_a0;
      hist0   <= sync_b0;
      sync_a1 <= b1_data_i;
      sync_b1 <= sync_a1;
      hist1   <= sync_b1;
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (wr) begin
        case (addr_i)
          4'h0: out0 <= wdata_i[B0_BW-1:0];
          4'h1: out1 <= wdata_i[B1_BW-1:0];
          4'h2: dir0 <= wdata_i[B0_BW-1:0];
          4'h3: dir1 <= wdata_i[B1_BW-1:0];
          4'h6: ie0  <= wdata_i[B0_BW-1:0];
          4'h7: ie1  <= wdata_i[B1_BW-1:0];
          default: ;
        endcase
      end
      // A fresh edge overrides a same-cycle clear of that bit.
      is0   <= (is0 & ~clr0) | rise0;
      is1   <= (is1 & ~clr1) | rise1;
      irq_o <= (|(is0 & ie0)) | (|(is1 & ie1));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gpio_ctrl : scoreboard bench for gpio_ctrl against a cycle-indexed model
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_gpio_ctrl;
  localparam int B1W = 6;
  localparam int B0W = 8;
  localparam logic [7:0] M1 = 8'h3F;
  localparam logic [7:0] M0 = 8'hFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic ack, irq;
  logic [B1W-1:0] b1_do, b1_oe, b1_di;
  logic [B0W-1:0] b0_do, b0_oe, b0_di;
  logic [7:0] p0 = 8'h00, p1 = 8'h00;
  logic [7:0] q0 = 8'h00, q1 = 8'h00;

  assign b0_di = p0[B0W-1:0];
  assign b1_di = p1[B1W-1:0];

  always #5 clk = ~clk;

  gpio_ctrl #(.B1_BW(B1W), .B0_BW(B0W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack),
    .b1_data_o(b1_do), .b1_oe_o(b1_oe), .b1_data_i(b1_di),
    .b0_data_o(b0_do), .b0_oe_o(b0_oe), .b0_data_i(b0_di),
    .irq_o(irq)
  );

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  // Reference model: register file plus a per-cycle history of pad samples.
  logic [7:0] m_out0 = 0, m_out1 = 0, m_dir0 = 0, m_dir1 = 0;
  logic [7:0] m_ie0 = 0, m_ie1 = 0, m_is0 = 0, m_is1 = 0;
  logic       m_irq = 0;
  logic [7:0] ph0 [0:4095];
  logic [7:0] ph1 [0:4095];
  int cyc = 0;

  task automatic model_step();
    logic [7:0] rd, r0, r1, c0, c1;
    logic nirq;
    exp_t e;
    edge_n++;
    if (!rst_n) begin
      m_out0 = 0; m_out1 = 0; m_dir0 = 0; m_dir1 = 0;
      m_ie0 = 0; m_ie1 = 0; m_is0 = 0; m_is1 = 0; m_irq = 0;
      cyc = 0;
      sb.delete();
      return;
    end
    ph0[cyc] = p0 & M0;
    ph1[cyc] = p1 & M1;
    r0 = 0; r1 = 0;
    // Pad sample k reaches the edge detector two cycles later.
    if (cyc >= 3) begin
      r0 = ph0[cyc-2] & ~ph0[cyc-3];
      r1 = ph1[cyc-2] & ~ph1[cyc-3];
    end
    if (req) begin
      rd = 8'h00;
      if (!we) begin
        case (addr)
          4'h0: rd = m_out0;
          4'h1: rd = m_out1;
          4'h2: rd = m_dir0;
          4'h3: rd = m_dir1;
          4'h4: rd = (cyc >= 2) ? ph0[cyc-2] : 8'h00;
          4'h5: rd = (cyc >= 2) ? ph1[cyc-2] : 8'h00;
          4'h6: rd = m_ie0;
          4'h7: rd = m_ie1;
          4'h8: rd = m_is0;
          4'h9: rd = m_is1;
          default: rd = 8'h00;
        endcase
      end
      e.due = edge_n;
      e.data = rd;
      sb.push_back(e);
    end
    nirq = (|(m_is0 & m_ie0)) | (|(m_is1 & m_ie1));
    c0 = 0; c1 = 0;
    if (req && we) begin
      case (addr)
        4'h0: m_out0 = wdata & M0;
        4'h1: m_out1 = wdata & M1;
        4'h2: m_dir0 = wdata & M0;
        4'h3: m_dir1 = wdata & M1;
        4'h6: m_ie0  = wdata & M0;
        4'h7: m_ie1  = wdata & M1;
        4'h8: c0 = wdata & M0;
        4'h9: c1 = wdata & M1;
        default: ;
      endcase
    end
    m_is0 = (m_is0 & ~c0) | r0;
    m_is1 = (m_is1 & ~c1) | r1;
    m_irq = nirq;
    if (cyc < 4095) cyc++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("b0_data_o", 8'(b0_do), m_out0);
        chk("b0_oe_o", 8'(b0_oe), m_dir0);
        chk("b1_data_o", 8'(b1_do), m_out1);
        chk("b1_oe_o", 8'(b1_oe), m_dir1);
        chk("irq_o", 8'(irq), 8'(m_irq));
        if (sb.size() > 0 && sb[0].due == edge_n) begin
          chk("ack", 8'(ack), 8'h01);
          chk("rdata", rdata, sb[0].data);
          sb.delete(0);
        end else begin
          chk("ack_idle", 8'(ack), 8'h00);
          chk("rdata_idle", rdata, 8'h00);
        end
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [3:0] a,
                      input logic [7:0] d, input logic rn);
    @(negedge clk);
    rst_n = rn; req = r; we = w; addr = a; wdata = d;
    p0 = q0; p1 = q1;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, 1'b1);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, a, 8'h00, 1'b1);
  endtask

  initial begin
    logic r, w, rn;
    logic [3:0] a;
    q0 = 8'hFF; q1 = 8'h00;
    step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
    idle(5);
    rd(4'h8); rd(4'h4);
    wr(4'h2, 8'h0F); wr(4'h0, 8'hA5); rd(4'h0); rd(4'h2);
    wr(4'h1, 8'hFF); rd(4'h1);
    wr(4'h7, 8'h08);
    q1 = 8'h08;
    idle(5);
    rd(4'h9);
    wr(4'h9, 8'h08);
    idle(3);
    rd(4'h9);
    wr(4'h6, 8'h01);
    q0 = 8'hFE; idle(4);
    q0 = 8'hFF; idle(5);
    q0 = 8'hFE; idle(3);
    q0 = 8'hFF;
    idle(2);
    wr(4'h8, 8'h01);
    idle(2);
    rd(4'h8);
    rd(4'h4); rd(4'hF); rd(4'h5);
    wr(4'h4, 8'hFF); rd(4'h4);
    wr(4'hC, 8'h55); rd(4'hC);
    step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
    idle(4);
    rd(4'h0); rd(4'h2); rd(4'h6); rd(4'h8);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) q0 = q0 ^ 8'($urandom);
      if ($urandom_range(0, 3) == 0) q1 = q1 ^ 8'($urandom);
      rn = ($urandom_range(0, 99) != 0);
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                       : 4'($urandom_range(0, 9));
      step(r, w, a, 8'($urandom), rn);
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
